// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared MEM->WB lane types and result-select encodings.
//               lane_mw_t bundles every field carried for one instruction
//               across the MEM/WB boundary.
// Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    // Datapath width carried inside lane_mw_t.
    localparam int unsigned C_XLEN = 32;

    // Result-select encodings used by the writeback mux.
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC8 = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [C_XLEN-1:0] alu;
        logic [C_XLEN-1:0] rdata;
        logic [C_XLEN-1:0] pc8;
        logic [1:0]        rsrc;
        logic              regwrite;
        logic [4:0]        rd;
    } lane_mw_t;

    // An empty slot: nothing valid, nothing written, every field zero.
    function automatic lane_mw_t bubble();
        lane_mw_t b;
        b      = '0;
        b.rsrc = RES_ALU;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_dual_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_dual_reg_if
// Description : MEM->WB bus for the dual-lane pipeline register.
//               Inputs : StallW, FlushW, per-lane M-stage fields (Valid,
//                        ALUResult, ReadData, PCPlus8, ResultSrc, RegWrite, Rd)
//               Outputs: per-lane registered W-stage fields, RetireCntW,
//                        RetireNowW
//               master = upstream/observer side, slave = the register.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_wb_dual_reg_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             StallW;
    logic             FlushW;

    logic             ValidM1,     ValidM2;
    logic [XLEN-1:0]  ALUResultM1, ALUResultM2;
    logic [XLEN-1:0]  ReadDataM1,  ReadDataM2;
    logic [XLEN-1:0]  PCPlus8M1,   PCPlus8M2;
    logic [1:0]       ResultSrcM1, ResultSrcM2;
    logic             RegWriteM1,  RegWriteM2;
    logic [4:0]       RdM1,        RdM2;

    logic             ValidW1,     ValidW2;
    logic [XLEN-1:0]  ALUResultW1, ALUResultW2;
    logic [XLEN-1:0]  ReadDataW1,  ReadDataW2;
    logic [XLEN-1:0]  PCPlus8W1,   PCPlus8W2;
    logic [1:0]       ResultSrcW1, ResultSrcW2;
    logic             RegWriteW1,  RegWriteW2;
    logic [4:0]       RdW1,        RdW2;

    logic [CNT_W-1:0] RetireCntW;
    logic [1:0]       RetireNowW;

    modport master (
        output StallW, FlushW,
        output ValidM1, ALUResultM1, ReadDataM1, PCPlus8M1, ResultSrcM1, RegWriteM1, RdM1,
        output ValidM2, ALUResultM2, ReadDataM2, PCPlus8M2, ResultSrcM2, RegWriteM2, RdM2,
        input  ValidW1, ALUResultW1, ReadDataW1, PCPlus8W1, ResultSrcW1, RegWriteW1, RdW1,
        input  ValidW2, ALUResultW2, ReadDataW2, PCPlus8W2, ResultSrcW2, RegWriteW2, RdW2,
        input  RetireCntW, RetireNowW
    );

    modport slave (
        input  StallW, FlushW,
        input  ValidM1, ALUResultM1, ReadDataM1, PCPlus8M1, ResultSrcM1, RegWriteM1, RdM1,
        input  ValidM2, ALUResultM2, ReadDataM2, PCPlus8M2, ResultSrcM2, RegWriteM2, RdM2,
        output ValidW1, ALUResultW1, ReadDataW1, PCPlus8W1, ResultSrcW1, RegWriteW1, RdW1,
        output ValidW2, ALUResultW2, ReadDataW2, PCPlus8W2, ResultSrcW2, RegWriteW2, RdW2,
        output RetireCntW, RetireNowW
    );
endinterface
`default_nettype wire

// File: rtl/mw_lane_reg.sv
`default_nettype none
// ============================================================================
// Module      : mw_lane_reg
// Description : One MEM->WB lane register.
//               clk, rst : clock, synchronous active-high reset
//               i_stall  : hold the lane
//               i_flush  : load a bubble (wins over i_stall)
//               i_kill   : suppress this lane's register write
//               i_lane   : M-stage fields
//               o_lane   : registered W-stage fields
// Revision    : 1.0  initial release
// ============================================================================
module mw_lane_reg
    import core_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_stall,
    input  logic     i_flush,
    input  logic     i_kill,
    input  lane_mw_t i_lane,
    output lane_mw_t o_lane
);

    lane_mw_t r_q;
    lane_mw_t w_d;

    // Only the write enable is qualified; data fields pass through untouched
    // so a killed or invalid slot still shows what the M stage presented.
    always_comb begin
        w_d          = i_lane;
        w_d.regwrite = i_lane.regwrite & i_lane.valid & (i_lane.rd != 5'd0) & ~i_kill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= bubble();
        end else if (i_flush) begin
            r_q <= bubble();
        end else if (!i_stall) begin
            r_q <= w_d;
        end
    end

    assign o_lane = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_dual_reg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_dual_reg
// Description : Dual-lane MEM->WB pipeline register with stall, flush,
//               same-cycle WAW suppression and a retired-instruction counter.
//               clk, rst : clock, synchronous active-high reset
//               bus      : mem_wb_dual_reg_if.slave (M inputs, W outputs,
//                          StallW/FlushW, RetireCntW, RetireNowW)
//               Lane 1 is always the older instruction of the pair.
//               XLEN must equal core_pkg::C_XLEN; CNT_W must be >= 2.
// Revision    : 1.0  initial release
// ============================================================================
module mem_wb_dual_reg
    import core_pkg::*;
#(
    parameter int XLEN  = C_XLEN,
    parameter int CNT_W = 64
) (
    input logic               clk,
    input logic               rst,
    mem_wb_dual_reg_if.slave  bus
);

    lane_mw_t         w_m1, w_m2;
    lane_mw_t         w_w1, w_w2;
    logic             w_kill1;
    logic [1:0]       w_now;
    logic [CNT_W-1:0] r_cnt;

    assign w_m1 = '{valid: bus.ValidM1, alu: bus.ALUResultM1, rdata: bus.ReadDataM1,
                    pc8: bus.PCPlus8M1, rsrc: bus.ResultSrcM1, regwrite: bus.RegWriteM1,
                    rd: bus.RdM1};
    assign w_m2 = '{valid: bus.ValidM2, alu: bus.ALUResultM2, rdata: bus.ReadDataM2,
                    pc8: bus.PCPlus8M2, rsrc: bus.ResultSrcM2, regwrite: bus.RegWriteM2,
                    rd: bus.RdM2};

    // Younger lane 2 owns the register on a same-cycle WAW, so the register
    // file never sees two writes to one register in one cycle.
    assign w_kill1 = bus.ValidM2 & bus.RegWriteM2 & (bus.RdM2 == bus.RdM1);

    mw_lane_reg u_lane1 (
        .clk     (clk),
        .rst     (rst),
        .i_stall (bus.StallW),
        .i_flush (bus.FlushW),
        .i_kill  (w_kill1),
        .i_lane  (w_m1),
        .o_lane  (w_w1)
    );

    mw_lane_reg u_lane2 (
        .clk     (clk),
        .rst     (rst),
        .i_stall (bus.StallW),
        .i_flush (bus.FlushW),
        .i_kill  (1'b0),
        .i_lane  (w_m2),
        .o_lane  (w_w2)
    );

    // Counts what leaves W, not what enters it: a flush does not stop the
    // current occupants from retiring, a stall does.
    assign w_now = bus.StallW ? 2'd0 : ({1'b0, w_w1.valid} + {1'b0, w_w2.valid});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(w_now);
        end
    end

    assign bus.ValidW1     = w_w1.valid;
    assign bus.ALUResultW1 = XLEN'(w_w1.alu);
    assign bus.ReadDataW1  = XLEN'(w_w1.rdata);
    assign bus.PCPlus8W1   = XLEN'(w_w1.pc8);
    assign bus.ResultSrcW1 = w_w1.rsrc;
    assign bus.RegWriteW1  = w_w1.regwrite;
    assign bus.RdW1        = w_w1.rd;

    assign bus.ValidW2     = w_w2.valid;
    assign bus.ALUResultW2 = XLEN'(w_w2.alu);
    assign bus.ReadDataW2  = XLEN'(w_w2.rdata);
    assign bus.PCPlus8W2   = XLEN'(w_w2.pc8);
    assign bus.ResultSrcW2 = w_w2.rsrc;
    assign bus.RegWriteW2  = w_w2.regwrite;
    assign bus.RdW2        = w_w2.rd;

    assign bus.RetireCntW  = r_cnt;
    assign bus.RetireNowW  = w_now;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_dual_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_dual_reg
// Description : Self-checking bench for mem_wb_dual_reg (XLEN=32, CNT_W=4).
//               Expected W state is pushed to a scoreboard queue as each
//               cycle's stimulus is applied and popped after the edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_wb_dual_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic        v;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [31:0] pc8;
        logic [1:0]  src;
        logic        we;
        logic [4:0]  rd;
    } lane_t;

    typedef struct packed {
        lane_t      w1;
        lane_t      w2;
        logic [3:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_wb_dual_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) u_bus ();

    mem_wb_dual_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus.slave)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    exp_t  sb[$];

    // stimulus for the next cycle
    logic  s_rst, s_stall, s_flush;
    lane_t s_in1, s_in2;

    // reference state
    lane_t      m_w1, m_w2;
    logic [3:0] m_cnt;
    logic       m_known = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_lane(input string pfx, input lane_t obs, input lane_t exp);
        check({pfx, ".valid"},    64'(obs.v),    64'(exp.v));
        check({pfx, ".alu"},      64'(obs.alu),  64'(exp.alu));
        check({pfx, ".rdata"},    64'(obs.rdat), 64'(exp.rdat));
        check({pfx, ".pc8"},      64'(obs.pc8),  64'(exp.pc8));
        check({pfx, ".rsrc"},     64'(obs.src),  64'(exp.src));
        check({pfx, ".regwrite"}, 64'(obs.we),   64'(exp.we));
        check({pfx, ".rd"},       64'(obs.rd),   64'(exp.rd));
    endtask

    function automatic lane_t rnd_lane();
        lane_t l;
        l.v    = 1'($urandom_range(0, 1));
        l.alu  = $urandom;
        l.rdat = $urandom;
        l.pc8  = $urandom;
        l.src  = 2'($urandom_range(0, 2));
        l.we   = 1'($urandom_range(0, 1));
        l.rd   = 5'($urandom_range(0, 31));
        return l;
    endfunction

    function automatic lane_t idle_lane();
        lane_t l;
        l   = rnd_lane();
        l.v = 1'b0;
        return l;
    endfunction

    // Valid writing lane with a chosen destination.
    function automatic lane_t wr_lane(input logic [4:0] rd);
        lane_t l;
        l    = rnd_lane();
        l.v  = 1'b1;
        l.we = 1'b1;
        l.rd = rd;
        return l;
    endfunction

    // One clock: apply stimulus, check the combinational retire count,
    // predict the post-edge state, then compare after the edge.
    task automatic cycle();
        exp_t       nx, got;
        logic [1:0] now_exp;
        lane_t      o1, o2;
        logic       k1;

        rst               = s_rst;
        u_bus.StallW      = s_stall;
        u_bus.FlushW      = s_flush;
        u_bus.ValidM1     = s_in1.v;    u_bus.ValidM2     = s_in2.v;
        u_bus.ALUResultM1 = s_in1.alu;  u_bus.ALUResultM2 = s_in2.alu;
        u_bus.ReadDataM1  = s_in1.rdat; u_bus.ReadDataM2  = s_in2.rdat;
        u_bus.PCPlus8M1   = s_in1.pc8;  u_bus.PCPlus8M2   = s_in2.pc8;
        u_bus.ResultSrcM1 = s_in1.src;  u_bus.ResultSrcM2 = s_in2.src;
        u_bus.RegWriteM1  = s_in1.we;   u_bus.RegWriteM2  = s_in2.we;
        u_bus.RdM1        = s_in1.rd;   u_bus.RdM2        = s_in2.rd;
        #1;

        now_exp = 2'd0;
        if (!s_stall) now_exp = 2'(m_w1.v) + 2'(m_w2.v);
        if (m_known) check("RetireNowW", 64'(u_bus.RetireNowW), 64'(now_exp));

        if (s_rst) begin
            nx = '0;
        end else begin
            nx.cnt = m_cnt + 4'(now_exp);
            if (s_flush) begin
                nx.w1 = '0;
                nx.w2 = '0;
            end else if (s_stall) begin
                nx.w1 = m_w1;
                nx.w2 = m_w2;
            end else begin
                k1    = s_in2.v && s_in2.we && (s_in2.rd == s_in1.rd);
                nx.w1 = s_in1;
                nx.w2 = s_in2;
                nx.w1.we = s_in1.we && s_in1.v && (s_in1.rd != 0) && !k1;
                nx.w2.we = s_in2.we && s_in2.v && (s_in2.rd != 0);
            end
        end
        sb.push_back(nx);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        o1  = '{v: u_bus.ValidW1, alu: u_bus.ALUResultW1, rdat: u_bus.ReadDataW1,
                pc8: u_bus.PCPlus8W1, src: u_bus.ResultSrcW1, we: u_bus.RegWriteW1,
                rd: u_bus.RdW1};
        o2  = '{v: u_bus.ValidW2, alu: u_bus.ALUResultW2, rdat: u_bus.ReadDataW2,
                pc8: u_bus.PCPlus8W2, src: u_bus.ResultSrcW2, we: u_bus.RegWriteW2,
                rd: u_bus.RdW2};
        check_lane("W1", o1, got.w1);
        check_lane("W2", o2, got.w2);
        check("RetireCntW", 64'(u_bus.RetireCntW), 64'(got.cnt));
        m_w1    = got.w1;
        m_w2    = got.w2;
        m_cnt   = got.cnt;
        m_known = 1'b1;
    endtask

    task automatic go(input logic r, input logic st, input logic fl,
                      input lane_t a, input lane_t b);
        s_rst = r; s_stall = st; s_flush = fl; s_in1 = a; s_in2 = b;
        cycle();
    endtask

    initial begin
        // 1: reset with random inputs and random stall/flush
        for (int i = 0; i < 2; i++)
            go(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_lane(), rnd_lane());

        // 2: basic load, lane 1 ALU result, lane 2 load data
        s_in1 = wr_lane(5'd5); s_in1.alu  = 32'h0000_1234; s_in1.src = 2'b00;
        s_in2 = wr_lane(5'd6); s_in2.rdat = 32'hDEAD_BEEF; s_in2.src = 2'b01;
        go(1'b0, 1'b0, 1'b0, s_in1, s_in2);
        check("basic.we1", 64'(u_bus.RegWriteW1), 64'd1);
        check("basic.we2", 64'(u_bus.RegWriteW2), 64'd1);
        go(1'b0, 1'b0, 1'b0, idle_lane(), idle_lane());
        check("basic.cnt", 64'(u_bus.RetireCntW), 64'd2);

        // 3: WAW on x7, then both lanes targeting x0
        go(1'b0, 1'b0, 1'b0, wr_lane(5'd7), wr_lane(5'd7));
        check("waw.we1", 64'(u_bus.RegWriteW1), 64'd0);
        check("waw.we2", 64'(u_bus.RegWriteW2), 64'd1);
        go(1'b0, 1'b0, 1'b0, wr_lane(5'd0), wr_lane(5'd0));
        check("x0.we1", 64'(u_bus.RegWriteW1), 64'd0);
        check("x0.we2", 64'(u_bus.RegWriteW2), 64'd0);
        // older lane writes, younger lane valid but not writing same rd
        s_in2 = wr_lane(5'd9); s_in2.we = 1'b0;
        go(1'b0, 1'b0, 1'b0, wr_lane(5'd9), s_in2);
        check("nokill.we1", 64'(u_bus.RegWriteW1), 64'd1);

        // 4: load a pair, stall three cycles, then stall together with flush
        go(1'b0, 1'b0, 1'b0, wr_lane(5'd3), wr_lane(5'd4));
        for (int i = 0; i < 3; i++)
            go(1'b0, 1'b1, 1'b0, wr_lane(5'd11), wr_lane(5'd12));
        go(1'b0, 1'b1, 1'b1, wr_lane(5'd13), wr_lane(5'd14));
        check("flush.v1", 64'(u_bus.ValidW1), 64'd0);
        check("flush.v2", 64'(u_bus.ValidW2), 64'd0);

        // 5: counter wrap, two retirements per edge, eight increments from 0
        go(1'b1, 1'b0, 1'b0, idle_lane(), idle_lane());
        go(1'b0, 1'b0, 1'b0, wr_lane(5'd1), wr_lane(5'd2));
        for (int i = 0; i < 8; i++)
            go(1'b0, 1'b0, 1'b0, wr_lane(5'd1), wr_lane(5'd2));
        check("wrap.cnt", 64'(u_bus.RetireCntW), 64'd0);

        // 6: reset while stalled with a non-zero count, then a lone lane 2
        go(1'b0, 1'b0, 1'b0, wr_lane(5'd8), wr_lane(5'd10));
        go(1'b0, 1'b0, 1'b0, idle_lane(), idle_lane());
        go(1'b1, 1'b1, 1'b0, wr_lane(5'd8), wr_lane(5'd10));
        check("midrst.cnt", 64'(u_bus.RetireCntW), 64'd0);
        go(1'b0, 1'b0, 1'b0, idle_lane(), wr_lane(5'd15));
        go(1'b0, 1'b0, 1'b0, idle_lane(), idle_lane());
        check("lone.cnt", 64'(u_bus.RetireCntW), 64'd1);

        // random traffic with occasional stall and flush
        for (int i = 0; i < 40; i++)
            go(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
               rnd_lane(), rnd_lane());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
